// File: rtl/dds_trig_sequencer_if.sv
// Host/downstream bundle for dds_trig_sequencer: config inputs, per-frame pulses and frame-stable fields.
// With TRIG_BURST_EN defined, it also carries cfg_burst and burst_done.
interface dds_trig_sequencer_if #(
    parameter int CNT_W = 32,
    parameter int PW_W  = 8
);
    logic             enable;
    logic             cfg_load;
    logic [CNT_W-1:0] cfg_prt;
    logic [CNT_W-1:0] cfg_t2_dly;
    logic [PW_W-1:0]  cfg_pw;
    logic [CNT_W-1:0] cfg_ct_per;
    logic [1:0]       cfg_tv_mode;
    logic             ad9914_update_2;
    logic             ad9914_trig_1;
    logic             ad9914_trig_2;
    logic [CNT_W-1:0] ct_period;
    logic [1:0]       tv_mode;
    logic             busy;
    logic             cfg_err;
`ifdef TRIG_BURST_EN
    logic [15:0]      cfg_burst;
    logic             burst_done;
`endif

    modport master (
`ifdef TRIG_BURST_EN
        output cfg_burst,
        input  burst_done,
`endif
        output enable, cfg_load, cfg_prt, cfg_t2_dly, cfg_pw, cfg_ct_per, cfg_tv_mode,
        input  ad9914_update_2, ad9914_trig_1, ad9914_trig_2, ct_period, tv_mode, busy, cfg_err
    );

    modport slave (
`ifdef TRIG_BURST_EN
        input  cfg_burst,
        output burst_done,
`endif
        input  enable, cfg_load, cfg_prt, cfg_t2_dly, cfg_pw, cfg_ct_per, cfg_tv_mode,
        output ad9914_update_2, ad9914_trig_1, ad9914_trig_2, ct_period, tv_mode, busy, cfg_err
    );
endinterface

// File: rtl/dds_trig_sequencer.sv
// Frame timing generator for AD9914 update/trigger pulses with double-buffered config; TRIG_BURST_EN adds burst mode.
// Latency: update_2/trig_1 one cycle after enable is seen in IDLE; no backpressure, pulses are free-running.
module dds_trig_sequencer #(
    parameter int CNT_W = 32,
    parameter int PW_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    dds_trig_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FRAME_START, RUN} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] prt;
        logic [CNT_W-1:0] t2_dly;
        logic [PW_W-1:0]  pw;
        logic [CNT_W-1:0] ct_per;
        logic [1:0]       tv_mode;
`ifdef TRIG_BURST_EN
        logic [15:0]      burst;
`endif
    } cfg_t;

    function automatic logic [CNT_W-1:0] clamp_prt(input logic [CNT_W-1:0] p);
        return (p < CNT_W'(2)) ? CNT_W'(2) : p;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cfg_t             pend_q, pend_d;
    cfg_t             act_q, act_d;
    logic             pend_vld_q, pend_vld_d;
    logic             cfg_err_q, cfg_err_d;
    cfg_t             cfg_in, src;
    logic             start, burst_end, may_start, frame_last;
    logic [CNT_W-1:0] prt_use;
    logic [PW_W-1:0]  pw_use;
    logic [CNT_W:0]   cnt_x, pw_x, t2_lo_x, t2_hi_x;
`ifdef TRIG_BURST_EN
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             hold_q, hold_d;
    logic             burst_done_q, burst_done_d;
`endif

    always_comb begin
        cfg_in         = '0;
        cfg_in.prt     = bus.cfg_prt;
        cfg_in.t2_dly  = bus.cfg_t2_dly;
        cfg_in.pw      = bus.cfg_pw;
        cfg_in.ct_per  = bus.cfg_ct_per;
        cfg_in.tv_mode = bus.cfg_tv_mode;
`ifdef TRIG_BURST_EN
        cfg_in.burst   = bus.cfg_burst;
`endif
    end

    // A load arriving in the last cycle of a frame is forwarded straight into the new frame.
    assign src = bus.cfg_load ? cfg_in : pend_q;

    // Clamps are applied at use so an unconfigured start still yields a sane 2-cycle frame.
    assign prt_use    = clamp_prt(act_q.prt);
    assign pw_use     = (act_q.pw == '0) ? PW_W'(1) : act_q.pw;
    assign frame_last = (cnt_q == prt_use - CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        act_d      = act_q;
        cfg_err_d  = cfg_err_q;
        start      = 1'b0;
`ifdef TRIG_BURST_EN
        frame_cnt_d  = frame_cnt_q;
        hold_d       = hold_q;
        burst_done_d = 1'b0;
        burst_end    = (act_q.burst != 16'd0) && (frame_cnt_q >= act_q.burst);
        may_start    = !hold_q;
`else
        burst_end    = 1'b0;
        may_start    = 1'b1;
`endif

        if (bus.cfg_load) begin
            pend_d     = cfg_in;
            pend_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
`ifdef TRIG_BURST_EN
                if (!bus.enable) hold_d = 1'b0;
`endif
                if (bus.enable && may_start) begin
                    state_d = FRAME_START;
                    start   = 1'b1;
                end
            end
            FRAME_START: begin
                state_d = RUN;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            RUN: begin
                if (frame_last) begin
                    if (bus.enable && !burst_end) begin
                        state_d = FRAME_START;
                        start   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
`ifdef TRIG_BURST_EN
                        if (burst_end) begin
                            burst_done_d = 1'b1;
                            hold_d       = 1'b1;
                        end
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            cnt_d = '0;
            if (bus.cfg_load || pend_vld_q) begin
                act_d      = src;
                pend_vld_d = 1'b0;
                if (src.t2_dly >= clamp_prt(src.prt)) cfg_err_d = 1'b1;
            end
`ifdef TRIG_BURST_EN
            if (state_q == IDLE)
                frame_cnt_d = 16'd1;
            else if (frame_cnt_q != 16'hFFFF)
                frame_cnt_d = frame_cnt_q + 16'd1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_q     <= '0;
            act_q      <= '0;
            pend_vld_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            act_q      <= act_d;
            pend_vld_q <= pend_vld_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

`ifdef TRIG_BURST_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt_q  <= '0;
            hold_q       <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            hold_q       <= hold_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign bus.burst_done = burst_done_q;
`endif

    // One extra bit keeps t2_dly+pw from wrapping near the top of the counter range.
    assign cnt_x   = {1'b0, cnt_q};
    assign pw_x    = {{(CNT_W+1-PW_W){1'b0}}, pw_use};
    assign t2_lo_x = {1'b0, act_q.t2_dly};
    assign t2_hi_x = t2_lo_x + pw_x;

    assign bus.busy            = (state_q != IDLE);
    assign bus.ad9914_update_2 = (state_q == FRAME_START);
    assign bus.ad9914_trig_1   = (state_q != IDLE) && (cnt_x < pw_x);
    assign bus.ad9914_trig_2   = (state_q != IDLE) && (cnt_x >= t2_lo_x) && (cnt_x < t2_hi_x);
    assign bus.ct_period       = act_q.ct_per;
    assign bus.tv_mode         = act_q.tv_mode;
    assign bus.cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_dds_trig_sequencer.sv
// Directed bench for dds_trig_sequencer: table of frame configs with expected 20-cycle pulse masks,
// plus hand sequences for config boundary, stop, reset and (with TRIG_BURST_EN) burst mode.
module tb_dds_trig_sequencer;
    localparam int CNT_W = 32;
    localparam int PW_W  = 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dds_trig_sequencer_if #(.CNT_W(CNT_W), .PW_W(PW_W)) bus ();

    dds_trig_sequencer #(.CNT_W(CNT_W), .PW_W(PW_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] prt;
        logic [31:0] t2;
        logic [7:0]  pw;
        logic [31:0] ct;
        logic [1:0]  tv;
        logic [19:0] e_upd;
        logic [19:0] e_t1;
        logic [19:0] e_t2;
        logic        e_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b0;
        bus.enable   = 1'b0;
        bus.cfg_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load(input logic [31:0] prt, input logic [31:0] t2, input logic [7:0] pw,
                        input logic [31:0] ct, input logic [1:0] tv, input logic [15:0] burst);
        bus.cfg_prt     = prt;
        bus.cfg_t2_dly  = t2;
        bus.cfg_pw      = pw;
        bus.cfg_ct_per  = ct;
        bus.cfg_tv_mode = tv;
`ifdef TRIG_BURST_EN
        bus.cfg_burst   = burst;
`else
        if (burst != 16'd0) $display("note: burst value ignored in this build");
`endif
        bus.cfg_load = 1'b1;
        @(negedge clk);
        bus.cfg_load = 1'b0;
    endtask

    task automatic wait_upd(input string name, input int max);
        int n = 0;
        while (bus.ad9914_update_2 !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (bus.ad9914_update_2 !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no update_2 within %0d cycles", name, max);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: busy still high after 60 cycles", name);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {bus.ad9914_update_2, bus.ad9914_trig_1, bus.ad9914_trig_2, bus.busy,
                bus.cfg_err, bus.tv_mode, bus.ct_period};
    endfunction

    initial begin
        logic [19:0] m_upd, m_t1, m_t2;
        logic [9:0]  s_busy, s_t1, s_t2, s_upd;
        int          t0, t1;

        vecs[0] = '{prt:10, t2:4, pw:2, ct:32'h100, tv:2'd0,
                    e_upd:20'h00401, e_t1:20'h00C03, e_t2:20'h0C030, e_err:1'b0};
        vecs[1] = '{prt:8, t2:6, pw:5, ct:32'h101, tv:2'd1,
                    e_upd:20'h10101, e_t1:20'hF1F1F, e_t2:20'h0C0C0, e_err:1'b0};
        vecs[2] = '{prt:8, t2:8, pw:5, ct:32'h102, tv:2'd2,
                    e_upd:20'h10101, e_t1:20'hF1F1F, e_t2:20'h00000, e_err:1'b1};
        vecs[3] = '{prt:0, t2:0, pw:0, ct:32'h103, tv:2'd3,
                    e_upd:20'h55555, e_t1:20'h55555, e_t2:20'h55555, e_err:1'b0};
        vecs[4] = '{prt:3, t2:2, pw:1, ct:32'h104, tv:2'd0,
                    e_upd:20'h49249, e_t1:20'h49249, e_t2:20'h24924, e_err:1'b0};
        vecs[5] = '{prt:4, t2:1, pw:255, ct:32'h105, tv:2'd1,
                    e_upd:20'h11111, e_t1:20'hFFFFF, e_t2:20'hEEEEE, e_err:1'b0};
        vecs[6] = '{prt:4, t2:32'hFFFF_FFFE, pw:3, ct:32'h106, tv:2'd2,
                    e_upd:20'h11111, e_t1:20'h77777, e_t2:20'h00000, e_err:1'b1};

        rst             = 1'b0;
        bus.enable      = 1'b0;
        bus.cfg_load    = 1'b0;
        bus.cfg_prt     = '0;
        bus.cfg_t2_dly  = '0;
        bus.cfg_pw      = '0;
        bus.cfg_ct_per  = '0;
        bus.cfg_tv_mode = '0;
`ifdef TRIG_BURST_EN
        bus.cfg_burst   = '0;
`endif
        do_reset();
        check("reset_outputs", all_outs(), 64'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            load(vecs[i].prt, vecs[i].t2, vecs[i].pw, vecs[i].ct, vecs[i].tv, 16'd0);
            bus.enable = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_start_latency", i), bus.ad9914_update_2, 1'b1);
            for (int c = 0; c < 20; c++) begin
                m_upd[c] = bus.ad9914_update_2;
                m_t1[c]  = bus.ad9914_trig_1;
                m_t2[c]  = bus.ad9914_trig_2;
                if (c < 19) @(negedge clk);
            end
            check($sformatf("v%0d_update_2_mask", i), m_upd, vecs[i].e_upd);
            check($sformatf("v%0d_trig_1_mask", i), m_t1, vecs[i].e_t1);
            check($sformatf("v%0d_trig_2_mask", i), m_t2, vecs[i].e_t2);
            check($sformatf("v%0d_cfg_err", i), bus.cfg_err, vecs[i].e_err);
            check($sformatf("v%0d_ct_period", i), bus.ct_period, vecs[i].ct);
            check($sformatf("v%0d_tv_mode", i), bus.tv_mode, vecs[i].tv);
            bus.enable = 1'b0;
            wait_idle($sformatf("v%0d_idle", i));
        end

        // New config loaded mid-frame lands on the next boundary; a load in the start cycle waits one more frame.
        do_reset();
        load(10, 4, 2, 111, 2'd1, 16'd0);
        bus.enable = 1'b1;
        @(negedge clk);
        wait_upd("bnd_first", 5);
        t0 = cyc;
        check("bnd_ct_first", bus.ct_period, 111);
        repeat (3) @(negedge clk);
        load(20, 4, 2, 222, 2'd2, 16'd0);
        repeat (5) @(negedge clk);
        check("bnd_ct_before_edge", bus.ct_period, 111);
        check("bnd_no_early_update", bus.ad9914_update_2, 1'b0);
        @(negedge clk);
        check("bnd_update_at_10", bus.ad9914_update_2, 1'b1);
        check("bnd_len1", cyc - t0, 10);
        check("bnd_ct_second", bus.ct_period, 222);
        t1 = cyc;
        load(6, 2, 1, 333, 2'd3, 16'd0);
        wait_upd("bnd_third", 40);
        check("bnd_len2", cyc - t1, 20);
        check("bnd_ct_third", bus.ct_period, 333);
        t1 = cyc;
        @(negedge clk);
        wait_upd("bnd_fourth", 40);
        check("bnd_len3", cyc - t1, 6);
        bus.enable = 1'b0;
        wait_idle("bnd_idle");

        // enable dropped at cnt3: frame runs to cnt9 with pulses intact, then idles.
        do_reset();
        load(10, 8, 5, 7, 2'd0, 16'd0);
        bus.enable = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        bus.enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            s_busy[k] = bus.busy;
            s_t1[k]   = bus.ad9914_trig_1;
            s_t2[k]   = bus.ad9914_trig_2;
            s_upd[k]  = bus.ad9914_update_2;
        end
        check("stop_busy", s_busy, 10'h03F);
        check("stop_trig_1", s_t1, 10'h001);
        check("stop_trig_2", s_t2, 10'h030);
        check("stop_update_2", s_upd, 10'h000);

        // Reset at cnt5 clears everything, including a pending load.
        do_reset();
        load(10, 12, 2, 32'hABC, 2'd3, 16'd0);
        bus.enable = 1'b1;
        @(negedge clk);
        check("rst_err_set", bus.cfg_err, 1'b1);
        check("rst_ct_before", bus.ct_period, 32'hABC);
        repeat (2) @(negedge clk);
        load(10, 4, 2, 32'h555, 2'd1, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_midframe_outputs", all_outs(), 64'd0);
        bus.enable = 1'b0;
        @(negedge clk);
        rst        = 1'b1;
        bus.enable = 1'b1;
        @(negedge clk);
        check("rst_restart_update", bus.ad9914_update_2, 1'b1);
        check("rst_pending_discarded", bus.ct_period, 32'd0);
        check("rst_err_cleared", bus.cfg_err, 1'b0);
        bus.enable = 1'b0;
        wait_idle("rst_idle");

`ifdef TRIG_BURST_EN
        begin
            int n_upd, n_done, done_at;
            logic busy_at_done;
            do_reset();
            load(6, 0, 1, 9, 2'd0, 16'd3);
            bus.enable   = 1'b1;
            n_upd        = 0;
            n_done       = 0;
            done_at      = -1;
            busy_at_done = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.ad9914_update_2 === 1'b1) n_upd++;
                if (bus.burst_done === 1'b1) begin
                    n_done++;
                    done_at      = c;
                    busy_at_done = bus.busy;
                end
            end
            check("burst_updates", n_upd, 3);
            check("burst_done_count", n_done, 1);
            check("burst_done_pos", done_at, 18);
            check("burst_busy_at_done", busy_at_done, 1'b0);
            bus.enable = 1'b0;
            @(negedge clk);
            bus.enable = 1'b1;
            @(negedge clk);
            check("burst_restart", bus.ad9914_update_2, 1'b1);
            bus.enable = 1'b0;
            wait_idle("burst_idle");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
